// File: rtl/alu_operand_sequencer.sv
// Stimulus stage for the 4-bit ALU: issues one {A,B,op} vector per 3-cycle IDLE/EXEC/WB slot,
// sourced from a host-loaded FIFO (replay) or a 16-bit Fibonacci LFSR (random).
module alu_operand_sequencer #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic [1:0]  in_op,
  input  logic        start,
  input  logic        mode,
  input  logic        stop,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [1:0]  op,
  output logic        vec_valid,
  output logic [1:0]  phase,
  output logic        busy,
  output logic [15:0] slot_cnt,
  output logic [7:0]  underrun_cnt
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [1:0] {S_STOP = 2'd0, S_FIFO = 2'd1, S_LFSR = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    phase_reg, phase_next;
  logic          stop_pending_reg, stop_pending_next;
  logic [3:0]    a_reg, a_next, b_reg, b_next;
  logic [1:0]    op_reg, op_next;
  logic          vec_valid_reg, vec_valid_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [15:0]   slot_cnt_reg, slot_cnt_next;
  logic [7:0]    underrun_cnt_reg, underrun_cnt_next;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic          boundary, fifo_empty, fifo_full, do_push, do_pop, bypass, wr_en, stop_eff;
  logic [9:0]    head;
  logic [15:0]   lfsr_step;

  assign boundary   = (phase_reg == 2'd2);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign do_push    = in_valid && !fifo_full;
  assign head       = mem[rd_ptr_reg];
  assign stop_eff   = stop_pending_reg || stop;
  // A push that lands on a boundary while the FIFO is empty goes straight to the outputs.
  assign wr_en      = do_push && !bypass;
  assign lfsr_step  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  always_comb begin
    state_next        = state_reg;
    phase_next        = boundary ? 2'd0 : phase_reg + 2'd1;
    stop_pending_next = stop_pending_reg;
    a_next            = a_reg;
    b_next            = b_reg;
    op_next           = op_reg;
    vec_valid_next    = vec_valid_reg;
    lfsr_next         = lfsr_reg;
    slot_cnt_next     = slot_cnt_reg;
    underrun_cnt_next = underrun_cnt_reg;
    do_pop            = 1'b0;
    bypass            = 1'b0;

    if (boundary) begin
      vec_valid_next    = 1'b0;
      stop_pending_next = 1'b0;
      case (state_reg)
        S_FIFO: begin
          if (stop_eff) begin
            state_next = S_STOP;
          end else if (!fifo_empty || do_push) begin
            do_pop         = !fifo_empty;
            bypass         = fifo_empty;
            {a_next, b_next, op_next} = fifo_empty ? {in_a, in_b, in_op} : head;
            vec_valid_next = 1'b1;
            slot_cnt_next  = (slot_cnt_reg != 16'hFFFF) ? slot_cnt_reg + 16'd1 : slot_cnt_reg;
          end else begin
            underrun_cnt_next = (underrun_cnt_reg != 8'hFF) ? underrun_cnt_reg + 8'd1
                                                            : underrun_cnt_reg;
          end
        end
        S_LFSR: begin
          if (stop_eff) begin
            state_next = S_STOP;
          end else begin
            lfsr_next      = lfsr_step;
            a_next         = lfsr_step[3:0];
            b_next         = lfsr_step[7:4];
            op_next        = lfsr_step[9:8];
            vec_valid_next = 1'b1;
            slot_cnt_next  = (slot_cnt_reg != 16'hFFFF) ? slot_cnt_reg + 16'd1 : slot_cnt_reg;
          end
        end
        default: ;
      endcase
    end else if (stop && state_reg != S_STOP) begin
      stop_pending_next = 1'b1;
    end

    // Stop has priority over a same-cycle start; start while running is ignored.
    if (state_reg == S_STOP && start && !stop)
      state_next = mode ? S_LFSR : S_FIFO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_STOP;
      phase_reg        <= 2'd0;
      stop_pending_reg <= 1'b0;
      a_reg            <= 4'd0;
      b_reg            <= 4'd0;
      op_reg           <= 2'd0;
      vec_valid_reg    <= 1'b0;
      lfsr_reg         <= SEED;
      slot_cnt_reg     <= 16'd0;
      underrun_cnt_reg <= 8'd0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      stop_pending_reg <= stop_pending_next;
      a_reg            <= a_next;
      b_reg            <= b_next;
      op_reg           <= op_next;
      vec_valid_reg    <= vec_valid_next;
      lfsr_reg         <= lfsr_next;
      slot_cnt_reg     <= slot_cnt_next;
      underrun_cnt_reg <= underrun_cnt_next;
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_ptr_reg] <= {in_a, in_b, in_op};
  end

  assign in_ready     = !fifo_full;
  assign A            = a_reg;
  assign B            = b_reg;
  assign op           = op_reg;
  assign vec_valid    = vec_valid_reg;
  assign phase        = phase_reg;
  assign busy         = (state_reg != S_STOP);
  assign slot_cnt     = slot_cnt_reg;
  assign underrun_cnt = underrun_cnt_reg;
endmodule
